// File: rtl/alu_result_fifo.sv
// ============================================================================
// Module   : alu_result_fifo
// Purpose  : First-word-fall-through result buffer for the 4-bit arithmetic
//            unit. Each accepted {result, op} pair is stored, and the head
//            entry's zero/negative flags are derived from its result, so the
//            flags always agree with out_result.
// Ports    : clk, rst (async, active-high)
//            in_valid / in_ready / in_result[3:0] / in_op[1:0]   - upstream
//            out_valid / out_ready / out_result[3:0] / out_op[1:0]
//            out_zero / out_neg                                   - downstream
//            level[$clog2(DEPTH):0]  - entries currently stored
//            accept_cnt[7:0]         - accepted transfers, wraps 255 -> 0
// Params   : DEPTH (power of two, >= 2), DROP_NOP (discard op 2'b10 entries)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_fifo #(
    parameter int DEPTH    = 4,
    parameter bit DROP_NOP = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_result,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_result,
    output logic [1:0]               out_op,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               accept_cnt
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam logic [c_lw-1:0] c_full = c_lw'(DEPTH);
    localparam logic [1:0]      c_op_nop = 2'b10;

    // Entry layout: {op[1:0], result[3:0]}
    logic [5:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_lw-1:0] r_level;
    logic [7:0]      r_accept_cnt;

    logic       w_push;
    logic       w_store;
    logic       w_pop;
    logic [5:0] w_head;

    // in_ready depends only on registered occupancy, so a full FIFO never
    // accepts on the same cycle it is popped.
    assign in_ready  = (r_level != c_full);
    assign out_valid = (r_level != '0);

    assign w_push  = in_valid & in_ready;
    // A dropped no-op still completes its handshake; it just isn't stored.
    assign w_store = w_push & ~(DROP_NOP & (in_op == c_op_nop));
    assign w_pop   = out_valid & out_ready;

    // Storage array carries no reset; occupancy tracking makes stale
    // contents invisible.
    always_ff @(posedge clk) begin
        if (w_store && !rst) begin
            r_mem[r_wr_ptr] <= {in_op, in_result};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_accept_cnt <= '0;
        end else begin
            if (w_push) begin
                r_accept_cnt <= r_accept_cnt + 8'd1;
            end
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_level <= r_level + c_lw'(1);
                2'b01:   r_level <= r_level - c_lw'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // Head outputs are forced to zero while empty.
    assign out_result = out_valid ? w_head[3:0] : 4'd0;
    assign out_op     = out_valid ? w_head[5:4] : 2'd0;
    assign out_zero   = out_valid & (w_head[3:0] == 4'd0);
    assign out_neg    = out_valid & w_head[3];

    assign level      = r_level;
    assign accept_cnt = r_accept_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
// ============================================================================
// Module   : tb_alu_result_fifo
// Purpose  : Directed and randomized self-checking bench for alu_result_fifo.
//            Two instances share stimulus: one keeps no-ops, one drops them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_fifo;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_result;
    logic [1:0] in_op;
    logic       out_ready;

    logic       in_ready,   d_in_ready;
    logic       out_valid,  d_out_valid;
    logic [3:0] out_result, d_out_result;
    logic [1:0] out_op,     d_out_op;
    logic       out_zero,   d_out_zero;
    logic       out_neg,    d_out_neg;
    logic [2:0] level,      d_level;
    logic [7:0] accept_cnt, d_accept_cnt;

    int n_checks;
    int n_errors;
    logic [5:0] q[$];

    alu_result_fifo #(.DEPTH(4), .DROP_NOP(1'b0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op),
        .out_zero(out_zero), .out_neg(out_neg),
        .level(level), .accept_cnt(accept_cnt)
    );

    alu_result_fifo #(.DEPTH(4), .DROP_NOP(1'b1)) dut_d (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(d_in_ready),
        .in_result(in_result), .in_op(in_op),
        .out_valid(d_out_valid), .out_ready(out_ready),
        .out_result(d_out_result), .out_op(d_out_op),
        .out_zero(d_out_zero), .out_neg(d_out_neg),
        .level(d_level), .accept_cnt(d_accept_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] r, input logic [1:0] o);
        in_valid  = 1'b1;
        in_result = r;
        in_op     = o;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [3:0] r, input logic [1:0] o,
                            input logic z, input logic n);
        chk({tag, "_valid"},  out_valid,  1'b1);
        chk({tag, "_result"}, out_result, r);
        chk({tag, "_op"},     out_op,     o);
        chk({tag, "_zero"},   out_zero,   z);
        chk({tag, "_neg"},    out_neg,    n);
    endtask

    // One scoreboard-checked cycle against the DROP_NOP=0 instance.
    task automatic sb_cycle(input logic iv, input logic ordy, input logic [3:0] r,
                            input logic [1:0] o);
        int   sz;
        logic [5:0] h;
        sz = q.size();
        chk("sb_level", level, sz);
        chk("sb_in_ready", in_ready, (sz != 4));
        if (sz > 0) begin
            h = q[0];
            chk_head("sb_head", h[3:0], h[5:4], (h[3:0] == 4'd0), h[3]);
        end else begin
            chk("sb_empty_valid", out_valid, 1'b0);
        end
        in_valid  = iv;
        out_ready = ordy;
        in_result = r;
        in_op     = o;
        tick();
        if (ordy && sz > 0) h = q.pop_front();
        if (iv && sz != 4) q.push_back({o, r});
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_result = 4'd0;
        in_op     = 2'd0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_accept", accept_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_result", out_result, 0);
        rst = 1'b0;

        // 1. Single push, latency 1
        chk("pre_push_valid", out_valid, 0);
        push_one(4'h5, 2'b00);
        chk_head("t1", 4'h5, 2'b00, 1'b0, 1'b0);
        chk("t1_level", level, 1);
        chk("t1_accept", accept_cnt, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_pop_level", level, 0);
        chk("t1_pop_valid", out_valid, 0);
        chk("t1_empty_result", out_result, 0);
        chk("t1_empty_op", out_op, 0);

        // 2. Fill to full, stall, then drain in order
        push_one(4'h0, 2'b01);
        push_one(4'h8, 2'b11);
        push_one(4'h3, 2'b00);
        push_one(4'hF, 2'b11);
        chk("t2_full_ready", in_ready, 0);
        chk("t2_full_level", level, 4);
        chk("t2_accept", accept_cnt, 5);
        in_valid  = 1'b1;
        in_result = 4'h7;
        in_op     = 2'b00;
        tick();
        tick();
        chk("t2_stall_accept", accept_cnt, 5);
        chk("t2_stall_level", level, 4);
        chk_head("t2_hold", 4'h0, 2'b01, 1'b1, 1'b0);
        // Pop with in_valid still high: a full FIFO must not accept here.
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t2_popfull_level", level, 3);
        chk("t2_popfull_accept", accept_cnt, 5);
        chk_head("t2_h8", 4'h8, 2'b11, 1'b0, 1'b1);
        tick();
        chk_head("t2_h3", 4'h3, 2'b00, 1'b0, 1'b0);
        tick();
        chk_head("t2_hF", 4'hF, 2'b11, 1'b0, 1'b1);
        tick();
        out_ready = 1'b0;
        chk("t2_drain_level", level, 0);
        chk("t2_drain_valid", out_valid, 0);

        // 3. Concurrent push/pop at level 2 across pointer wrap
        push_one(4'hA, 2'b00);
        push_one(4'hB, 2'b01);
        chk("t3_level", level, 2);
        chk("t3_accept0", accept_cnt, 7);
        chk_head("t3_hA", 4'hA, 2'b00, 1'b0, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_op     = 2'b11;
        in_result = 4'h1; tick(); chk("t3_lv1", level, 2); chk_head("t3_hB", 4'hB, 2'b01, 1'b0, 1'b1);
        in_result = 4'h2; tick(); chk("t3_lv2", level, 2); chk_head("t3_h1", 4'h1, 2'b11, 1'b0, 1'b0);
        in_result = 4'h3; tick(); chk("t3_lv3", level, 2); chk_head("t3_h2", 4'h2, 2'b11, 1'b0, 1'b0);
        in_result = 4'h4; tick(); chk("t3_lv4", level, 2); chk_head("t3_h3", 4'h3, 2'b11, 1'b0, 1'b0);
        in_result = 4'h5; tick(); chk("t3_lv5", level, 2); chk_head("t3_h4", 4'h4, 2'b11, 1'b0, 1'b0);
        in_result = 4'h6; tick(); chk("t3_lv6", level, 2); chk_head("t3_h5", 4'h5, 2'b11, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("t3_accept", accept_cnt, 13);
        tick();
        chk_head("t3_h6", 4'h6, 2'b11, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        chk("t3_drain", out_valid, 0);

        // 4. No-op dropping vs keeping
        push_one(4'h0, 2'b10);
        push_one(4'hE, 2'b11);
        chk("t4_keep_level", level, 2);
        chk("t4_keep_accept", accept_cnt, 15);
        chk_head("t4_keep_h0", 4'h0, 2'b10, 1'b1, 1'b0);
        chk("t4_drop_level", d_level, 1);
        chk("t4_drop_accept", d_accept_cnt, 15);
        chk("t4_drop_result", d_out_result, 4'hE);
        chk("t4_drop_op", d_out_op, 2'b11);
        chk("t4_drop_neg", d_out_neg, 1);
        chk("t4_drop_zero", d_out_zero, 0);
        out_ready = 1'b1;
        tick();
        chk_head("t4_keep_hE", 4'hE, 2'b11, 1'b0, 1'b1);
        chk("t4_drop_empty", d_out_valid, 0);
        chk("t4_drop_empty_res", d_out_result, 0);
        tick();
        out_ready = 1'b0;
        chk("t4_keep_empty", out_valid, 0);

        // 5. Asynchronous reset mid-cycle
        push_one(4'h1, 2'b00);
        push_one(4'h2, 2'b00);
        push_one(4'h3, 2'b00);
        chk("t5_level3", level, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_level", level, 0);
        chk("t5_async_accept", accept_cnt, 0);
        chk("t5_async_result", out_result, 0);
        in_valid  = 1'b1;
        in_result = 4'h4;
        tick();
        in_valid = 1'b0;
        chk("t5_rsthigh_level", level, 0);
        chk("t5_rsthigh_accept", accept_cnt, 0);
        rst = 1'b0;
        push_one(4'h9, 2'b01);
        chk_head("t5_after", 4'h9, 2'b01, 1'b0, 1'b1);
        chk("t5_after_level", level, 1);
        chk("t5_after_accept", accept_cnt, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_after_empty", out_valid, 0);

        // 6a. accept_cnt wrap: 255 back-to-back transfers brings 1 -> 0
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_op     = 2'b00;
        for (int i = 0; i < 254; i++) begin
            in_result = i[3:0];
            tick();
        end
        chk("t6_cnt255", accept_cnt, 255);
        tick();
        chk("t6_cnt_wrap", accept_cnt, 0);
        chk("t6_stream_level", level, 1);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("t6_stream_empty", out_valid, 0);

        // 6b. Random valid/ready against a queue scoreboard
        q.delete();
        for (int i = 0; i < 300; i++) begin
            sb_cycle(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45),
                     4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 6; i++) begin
            sb_cycle(1'b0, 1'b1, 4'd0, 2'd0);
        end
        chk("t6_final_empty", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
